// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle integer ALU (RV32I/RV64I base ALU ops + optional M ops).
//
// Base ops complete in one registered cycle; multiply/divide iterate one bit
// per cycle over XLEN cycles. Valid/ready handshake on both sides, one op in
// flight at a time.
//
// Build option: define ALU_MC_MULDIV_EN to compile in the multiply/divide
// datapath and the BUSY state. Without it, every op[5]=1 code is illegal.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented          in_ready   block can accept
//   op[5:0]    operation code               rv1, rv2   operands (XLEN)
//   out_valid  result available             out_ready  consumer takes result
//   rvout      result (XLEN)                illegal    op was unsupported
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rvout,
  output logic            illegal
);

  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b01001;
  localparam logic [4:0] OP_SLT  = 5'b01010;
  localparam logic [4:0] OP_SLTU = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_SRL  = 5'b01101;
  localparam logic [4:0] OP_SRA  = 5'b11101;
  localparam logic [4:0] OP_OR   = 5'b01110;
  localparam logic [4:0] OP_AND  = 5'b01111;

`ifdef ALU_MC_MULDIV_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

  state_t            state_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   rvout_r;
  logic              illegal_r;

  logic [XLEN-1:0]   base_res_s;
  logic              base_legal_s;
  logic [SHW-1:0]    shamt_s;

  // Single-cycle base-op result, formed from the live inputs at accept time.
  always_comb begin
    shamt_s      = rv2[SHW-1:0];
    base_res_s   = {XLEN{1'b0}};
    base_legal_s = 1'b0;
    if (!op[5]) begin
      base_legal_s = 1'b1;
      case (op[4:0])
        OP_ADD:  base_res_s = rv1 + rv2;
        OP_SUB:  base_res_s = rv1 - rv2;
        OP_SLL:  base_res_s = rv1 << shamt_s;
        OP_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(rv2))};
        OP_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (rv1 < rv2)};
        OP_XOR:  base_res_s = rv1 ^ rv2;
        OP_SRL:  base_res_s = rv1 >> shamt_s;
        OP_SRA:  base_res_s = $signed(rv1) >>> shamt_s;
        OP_OR:   base_res_s = rv1 | rv2;
        OP_AND:  base_res_s = rv1 & rv2;
        default: begin
          base_res_s   = {XLEN{1'b0}};
          base_legal_s = 1'b0;
        end
      endcase
    end else begin
      base_res_s   = {XLEN{1'b0}};
      base_legal_s = 1'b0;
    end
  end

`ifdef ALU_MC_MULDIV_EN
  localparam logic [SHW-1:0]    CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0]    CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [2:0]        mfn_r;
  logic              a_neg_r;
  logic              b_neg_r;
  logic              div_zero_r;
  logic [XLEN-1:0]   mcand_r;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_r;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [SHW-1:0]    cnt_r;

  logic              m_op_s;
  logic              a_sgn_s;
  logic              b_sgn_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN:0]     mul_sum_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_diff_s;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   m_res_s;

  assign m_op_s = op[5] & (op[4:3] == 2'b00);

  // Operand signedness and magnitudes for the iterative datapath.
  always_comb begin
    if (op[2]) begin
      a_sgn_s = ~op[0];
      b_sgn_s = ~op[0];
    end else begin
      a_sgn_s = (op[1:0] == 2'b01) | (op[1:0] == 2'b10);
      b_sgn_s = (op[1:0] == 2'b01);
    end
    a_neg_s = a_sgn_s & rv1[XLEN-1];
    b_neg_s = b_sgn_s & rv2[XLEN-1];
    a_mag_s = a_neg_s ? (~rv1 + ONE_X) : rv1;
    b_mag_s = b_neg_s ? (~rv2 + ONE_X) : rv2;
  end

  // One shift-add or one restoring-divide step on the accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
    // Shifted remainder is XLEN+1 bits wide; after a successful subtract it is < divisor.
    div_ge_s   = (acc_r[2*XLEN-1:XLEN-1] >= {1'b0, mcand_r});
    div_diff_s = acc_r[2*XLEN-2:XLEN-1] - mcand_r;
    if (mfn_r[2]) begin
      if (div_ge_s) begin
        step_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {acc_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Final-cycle sign correction and result selection. The -2^(XLEN-1)/-1
  // overflow case falls out naturally: magnitude quotient 2^(XLEN-1), no negation.
  always_comb begin
    prod_fix_s = (a_neg_r ^ b_neg_r) ? (~step_s + ONE_2X) : step_s;
    quo_s      = step_s[XLEN-1:0];
    rem_s      = step_s[2*XLEN-1:XLEN];
    case (mfn_r)
      3'b000:  m_res_s = prod_fix_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  m_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100:  m_res_s = div_zero_r ? {XLEN{1'b1}} : ((a_neg_r ^ b_neg_r) ? (~quo_s + ONE_X) : quo_s);
      3'b101:  m_res_s = div_zero_r ? {XLEN{1'b1}} : quo_s;
      3'b110:  m_res_s = a_neg_r ? (~rem_s + ONE_X) : rem_s;
      3'b111:  m_res_s = rem_s;
      default: m_res_s = {XLEN{1'b0}};
    endcase
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      rvout_r     <= {XLEN{1'b0}};
      illegal_r   <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      cnt_r       <= {SHW{1'b0}};
      mfn_r       <= 3'b000;
      a_neg_r     <= 1'b0;
      b_neg_r     <= 1'b0;
      div_zero_r  <= 1'b0;
      mcand_r     <= {XLEN{1'b0}};
      acc_r       <= {(2*XLEN){1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
            if (m_op_s) begin
              state_r    <= ST_BUSY;
              in_ready_r <= 1'b0;
              cnt_r      <= {SHW{1'b0}};
              mfn_r      <= op[2:0];
              a_neg_r    <= a_neg_s;
              b_neg_r    <= b_neg_s;
              div_zero_r <= (rv2 == {XLEN{1'b0}});
              mcand_r    <= b_mag_s;
              acc_r      <= {{XLEN{1'b0}}, a_mag_s};
            end else
`endif
            begin
              state_r     <= ST_DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              rvout_r     <= base_res_s;
              illegal_r   <= ~base_legal_s;
            end
          end
        end
`ifdef ALU_MC_MULDIV_EN
        ST_BUSY: begin
          cnt_r <= cnt_r + CNT_ONE;
          acc_r <= step_s;
          if (cnt_r == CNT_LAST) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            rvout_r     <= m_res_s;
            illegal_r   <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // in_ready depends only on state and is held low while reset is asserted.
  assign in_ready  = in_ready_r & rst_n;
  assign out_valid = out_valid_r;
  assign rvout     = rvout_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- self-checking bench for alu_mc (XLEN=32), either build option.
module tb_alu_mc;

  localparam int XLEN = 32;
  localparam int SHW  = 5;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      op;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rvout;
  logic            illegal;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rv1(rv1), .rv2(rv2), .out_valid(out_valid),
    .out_ready(out_ready), .rvout(rvout), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference result {illegal, value} straight from the ISA definitions.
  function automatic logic [XLEN:0] model(input logic [5:0] o, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   minv;
    logic              ill;
    r    = '0;
    ill  = 1'b0;
    p    = '0;
    minv = {1'b1, {(XLEN-1){1'b0}}};
    if (!o[5]) begin
      case (o[4:0])
        5'b01000: r = a + b;
        5'b11000: r = a - b;
        5'b01001: r = a << b[SHW-1:0];
        5'b01010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        5'b01011: r = (a < b) ? 32'd1 : 32'd0;
        5'b01100: r = a ^ b;
        5'b01101: r = a >> b[SHW-1:0];
        5'b11101: r = $signed(a) >>> b[SHW-1:0];
        5'b01110: r = a | b;
        5'b01111: r = a & b;
        default:  ill = 1'b1;
      endcase
    end else begin
`ifdef ALU_MC_MULDIV_EN
      if (o[4:3] != 2'b00) ill = 1'b1;
      else begin
        case (o[2:0])
          3'd0: begin p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; r = p[XLEN-1:0]; end
          3'd1: begin p = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b}; r = p[2*XLEN-1:XLEN]; end
          3'd2: begin p = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b}; r = p[2*XLEN-1:XLEN]; end
          3'd3: begin p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; r = p[2*XLEN-1:XLEN]; end
          3'd4: if (b == 0) r = '1; else if (a == minv && b == '1) r = minv;
                else r = $signed(a) / $signed(b);
          3'd5: if (b == 0) r = '1; else r = a / b;
          3'd6: if (b == 0) r = a; else if (a == minv && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
          default: if (b == 0) r = a; else r = a % b;
        endcase
      end
`else
      ill = 1'b1;
`endif
    end
    return {ill, r};
  endfunction

  // Transaction-level expectation: one pending op, result due at a known cycle.
  int              cyc     = 0;
  bit              m_pend  = 1'b0;
  int              m_ready = 0;
  logic [XLEN-1:0] m_res;
  logic            m_ill;
  logic [XLEN:0]   mv;
  bit              ov_prev;
  bit              exp_ov;

  always @(posedge clk) begin
    ov_prev = m_pend && (cyc >= m_ready);
    cyc++;
    if (!rst_n) m_pend = 1'b0;
    else if (m_pend) begin
      if (ov_prev && out_ready) m_pend = 1'b0;
    end else if (in_valid) begin
      mv      = model(op, rv1, rv2);
      m_ill   = mv[XLEN];
      m_res   = mv[XLEN-1:0];
      m_pend  = 1'b1;
      m_ready = cyc + ((op[5] && !m_ill) ? XLEN : 0);
    end
  end

  // Every-cycle compare of the DUT against the expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ov = m_pend && (cyc >= m_ready);
      chk("cyc in_ready", 64'(in_ready), 64'(rst_n && !m_pend));
      chk("cyc out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
        chk("cyc rvout", 64'(rvout), 64'(m_res));
        chk("cyc illegal", 64'(illegal), 64'(m_ill));
      end
    end
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ill;
    logic        m;
    logic [3:0]  hold;
  } vec_t;

  localparam int NV = 31;
  localparam vec_t VECS [NV] = '{
    '{6'h08, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 4'd5},
    '{6'h18, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 4'd0},
    '{6'h1D, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd0},
    '{6'h0D, 32'h80000000, 32'h0000003F, 32'h00000001, 1'b0, 1'b0, 4'd0},
    '{6'h09, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 4'd0},
    '{6'h0A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4'd0},
    '{6'h0B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 4'd0},
    '{6'h0C, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 4'd0},
    '{6'h0E, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 4'd0},
    '{6'h0F, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 4'd0},
    '{6'h00, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 4'd1},
    '{6'h28, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 4'd0},
    '{6'h1F, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 4'd0},
    '{6'h21, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b1, 4'd5},
    '{6'h22, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 1'b1, 4'd0},
    '{6'h20, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 1'b1, 4'd0},
    '{6'h23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 4'd0},
    '{6'h20, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 1'b1, 4'd0},
    '{6'h21, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0},
    '{6'h24, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0},
    '{6'h26, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1'b1, 4'd0},
    '{6'h24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 4'd0},
    '{6'h26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 4'd0},
    '{6'h24, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b1, 4'd0},
    '{6'h26, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0},
    '{6'h25, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b1, 4'd0},
    '{6'h27, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b1, 4'd0},
    '{6'h25, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0},
    '{6'h27, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b1, 4'd0},
    '{6'h08, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 4'd0},
    '{6'h25, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0}
  };

  // Issue one vector (called at posedge+1 with the DUT idle), check, then take it.
  task automatic run_vec(input int i);
    vec_t            v;
    logic [XLEN-1:0] er;
    logic            ei;
    int              el;
    int              w;
    string           nm;
    v  = VECS[i];
    nm = $sformatf("v%0d", i);
    if (v.m && !MEN) begin
      er = '0; ei = 1'b1; el = 1;
    end else begin
      er = v.r; ei = v.ill; el = v.m ? XLEN + 1 : 1;
    end
    chk({nm, " model"}, 64'(model(v.op, v.a, v.b)), 64'({ei, er}));
    in_valid = 1'b1; op = v.op; rv1 = v.a; rv2 = v.b;
    @(posedge clk); #1;
    // Keep in_valid high with junk: it must be ignored while busy/done.
    op = 6'($urandom); rv1 = $urandom; rv2 = $urandom;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (out_valid !== 1'b1 && w < 200);
    chk({nm, " latency"}, 64'(w), 64'(el));
    chk({nm, " rvout"}, 64'(rvout), 64'(er));
    chk({nm, " illegal"}, 64'(illegal), 64'(ei));
    repeat (v.hold) begin
      @(negedge clk);
      chk({nm, " hold rvout"}, 64'(rvout), 64'(er));
      chk({nm, " hold in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk({nm, " in_ready after take"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; rv1 = '0; rv2 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'(0));
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset rvout", 64'(rvout), 64'(0));
    chk("reset illegal", 64'(illegal), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      run_vec(i);
    end

    // Reset pulse while an op is in flight: the result must never appear.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 6'h20; rv1 = 32'd3; rv2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort in_ready", 64'(in_ready), 64'(1));
    chk("abort out_valid", 64'(out_valid), 64'(0));
    chk("abort rvout", 64'(rvout), 64'(0));
    repeat (40) begin
      @(negedge clk);
      chk("abort no result", 64'(out_valid), 64'(0));
    end

    @(posedge clk); #1;
    run_vec(0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

endmodule
